stepper_sequencer: RTL and testbench

- Consumer end of the step-rate timing for the stepper PMOD on Basys3.
- Accepts a move command: step count, direction, step period in system clocks, and full/half mode.
- Drives the four coil-phase outputs through the half-step pattern table at the commanded rate.
- Reports busy and done, with a start/done handshake toward the control logic.

---
 rtl/stepper_pkg.sv | 21 ++
 rtl/step_rate_tick.sv | 28 ++
 rtl/stepper_sequencer.sv | 110 +++++++++++
 tb/tb_stepper_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper sequencer: FSM encoding, half-step coil table, index stepping.
package stepper_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam int MIN_PERIOD_DEF = 2;

  // Packed MSB-first, so PATTERN[0] is 4'b1000 and PATTERN[7] is 4'b1001.
  localparam logic [7:0][3:0] PATTERN = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic dir,
                                          input logic half);
    logic [2:0] step;
    step = half ? 3'd1 : 3'd2;
    return dir ? idx + step : idx - step;
  endfunction

endpackage

// File: rtl/step_rate_tick.sv
// Clearable period counter; tick is combinational while enabled and count == period-1.
// Clear dominates enable, so a cleared cycle never produces a tick-driven wrap.
module step_rate_tick #(
  parameter int PERIOD_W = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;

  assign tick = en && (count == period - PERIOD_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper move sequencer: walks the half-step coil table at a latched step period.
// Phase changes exactly one period after busy rises; start is ignored while a move is active.
module stepper_sequencer
  import stepper_pkg::*;
#(
  parameter int PERIOD_W   = 26,
  parameter int STEPS_W    = 16,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int HOLD       = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dir,
  input  logic                half,
  input  logic [STEPS_W-1:0]  steps,
  input  logic [PERIOD_W-1:0] period,
  input  logic                abort,
  output logic [3:0]          phase,
  output logic                busy,
  output logic                done,
  output logic [STEPS_W-1:0]  steps_left
);

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

  state_t              state;
  logic                dir_q;
  logic                half_q;
  logic [PERIOD_W-1:0] period_q;
  logic [2:0]          idx;
  logic [2:0]          start_idx;
  logic [2:0]          adv_idx;
  logic [PERIOD_W-1:0] period_cl;
  logic                tick;

  assign period_cl = (period < MIN_P) ? MIN_P : period;
  // Full-step mode only uses the two-coil (odd) entries.
  assign start_idx = half ? idx : {idx[2:1], 1'b1};
  assign adv_idx   = next_idx(idx, dir_q, half_q);

  step_rate_tick #(.PERIOD_W(PERIOD_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state != ST_RUN) || abort),
    .en     (state == ST_RUN),
    .period (period_q),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      phase      <= 4'b0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
      idx        <= 3'd0;
      dir_q      <= 1'b0;
      half_q     <= 1'b0;
      period_q   <= MIN_P;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            dir_q    <= dir;
            half_q   <= half;
            period_q <= period_cl;
            idx      <= start_idx;
            if (steps != '0) begin
              state      <= ST_RUN;
              busy       <= 1'b1;
              steps_left <= steps;
              phase      <= PATTERN[start_idx];
            end else begin
              state      <= ST_DONE;
              done       <= 1'b1;
              steps_left <= '0;
            end
          end
        end
        ST_RUN: begin
          // Abort outranks a coincident tick: no step, no decrement, no done.
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (HOLD == 0) phase <= 4'b0000;
          end else if (tick) begin
            idx        <= adv_idx;
            phase      <= PATTERN[adv_idx];
            steps_left <= steps_left - STEPS_W'(1);
            if (steps_left == STEPS_W'(1)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          if (HOLD == 0) phase <= 4'b0000;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed bench: table of moves with hand-computed phase sequences, plus abort/zero-step/reset cases.
module tb_stepper_sequencer;

  localparam int PW = 26;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, dir, half, abort;
  logic [SW-1:0] steps;
  logic [PW-1:0] period;
  logic [3:0]    phase, phase0;
  logic          busy, busy0, done, done0;
  logic [SW-1:0] steps_left, steps_left0;

  stepper_sequencer #(.PERIOD_W(PW), .STEPS_W(SW), .MIN_PERIOD(2), .HOLD(1)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .half(half), .steps(steps),
    .period(period), .abort(abort), .phase(phase), .busy(busy), .done(done),
    .steps_left(steps_left)
  );

  stepper_sequencer #(.PERIOD_W(PW), .STEPS_W(SW), .MIN_PERIOD(2), .HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .half(half), .steps(steps),
    .period(period), .abort(abort), .phase(phase0), .busy(busy0), .done(done0),
    .steps_left(steps_left0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            do_rst;
    logic            dir;
    logic            half;
    int              steps;
    int              period;
    int              interval;
    logic [3:0]      first;
    logic [3:0][3:0] chg;
  } move_t;

  move_t moves[5];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_phase", 32'(phase), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_steps_left", 32'(steps_left), 32'h0);
    rst = 1'b1;
  endtask

  task automatic wait_change(output int cyc);
    logic [3:0] prev;
    prev = phase;
    cyc  = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (phase === prev && cyc < 200);
  endtask

  task automatic run_move(input move_t m, input int id);
    int cyc;
    if (m.do_rst) do_reset();
    @(negedge clk);
    dir = m.dir; half = m.half; steps = SW'(m.steps); period = PW'(m.period); start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    period = PW'(999);
    chk($sformatf("m%0d_busy_rise", id), 32'(busy), 32'h1);
    chk($sformatf("m%0d_first_phase", id), 32'(phase), 32'(m.first));
    chk($sformatf("m%0d_steps_loaded", id), 32'(steps_left), 32'(m.steps));
    for (int k = 0; k < m.steps; k++) begin
      wait_change(cyc);
      chk($sformatf("m%0d_interval%0d", id, k), 32'(cyc), 32'(m.interval));
      chk($sformatf("m%0d_phase%0d", id, k), 32'(phase), 32'(m.chg[k]));
      chk($sformatf("m%0d_hold0_phase%0d", id, k), 32'(phase0), 32'(m.chg[k]));
      chk($sformatf("m%0d_left%0d", id, k), 32'(steps_left), 32'(m.steps - k - 1));
    end
    chk($sformatf("m%0d_done_pulse", id), 32'(done), 32'h1);
    chk($sformatf("m%0d_busy_fall", id), 32'(busy), 32'h0);
    @(negedge clk);
    chk($sformatf("m%0d_done_clear", id), 32'(done), 32'h0);
    chk($sformatf("m%0d_hold_phase", id), 32'(phase), 32'(m.chg[m.steps-1]));
    chk($sformatf("m%0d_hold0_idle", id), 32'(phase0), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic seen_done;

    rst = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0; half = 1'b0;
    steps = '0; period = '0;

    moves[0] = '{1'b1, 1'b1, 1'b1, 4, 10, 10, 4'b1000,
                 {4'b0010, 4'b0110, 4'b0100, 4'b1100}};
    moves[1] = '{1'b1, 1'b0, 1'b0, 3, 5, 5, 4'b1100,
                 {4'b0000, 4'b0110, 4'b0011, 4'b1001}};
    moves[2] = '{1'b0, 1'b1, 1'b1, 2, 0, 2, 4'b0110,
                 {4'b0000, 4'b0000, 4'b0011, 4'b0010}};
    moves[3] = '{1'b0, 1'b1, 1'b0, 2, 3, 3, 4'b0011,
                 {4'b0000, 4'b0000, 4'b1100, 4'b1001}};
    moves[4] = '{1'b0, 1'b0, 1'b1, 3, 4, 4, 4'b1100,
                 {4'b0000, 4'b0001, 4'b1001, 4'b1000}};

    for (int i = 0; i < 5; i++) run_move(moves[i], i);

    // Zero-step command from idx 6 (phase 0001): done only, no motion.
    @(negedge clk);
    dir = 1'b1; half = 1'b1; steps = '0; period = PW'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_busy", 32'(busy), 32'h0);
    chk("zero_phase", 32'(phase), 32'h1);
    @(negedge clk);
    chk("zero_done_clear", 32'(done), 32'h0);
    chk("zero_busy_after", 32'(busy), 32'h0);
    chk("zero_phase_after", 32'(phase), 32'h1);

    // Abort coinciding with the third tick; a start mid-run must be ignored.
    @(negedge clk);
    dir = 1'b1; half = 1'b1; steps = SW'(10); period = PW'(8); start = 1'b1;
    @(negedge clk);
    chk("ab_busy", 32'(busy), 32'h1);
    chk("ab_first", 32'(phase), 32'h1);
    dir = 1'b0; half = 1'b0; steps = SW'(1); period = PW'(2);
    @(negedge clk);
    start = 1'b0;
    chk("ab_restart_ignored", 32'(steps_left), 32'd10);
    wait_change(cyc);
    chk("ab_interval0", 32'(cyc), 32'd7);
    chk("ab_phase0", 32'(phase), 32'h9);
    chk("ab_left0", 32'(steps_left), 32'd9);
    wait_change(cyc);
    chk("ab_interval1", 32'(cyc), 32'd8);
    chk("ab_phase1", 32'(phase), 32'h8);
    chk("ab_left1", 32'(steps_left), 32'd8);
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy_fall", 32'(busy), 32'h0);
    chk("ab_phase_frozen", 32'(phase), 32'h8);
    chk("ab_left_frozen", 32'(steps_left), 32'd8);
    chk("ab_no_done", 32'(done), 32'h0);
    chk("ab_hold0_phase", 32'(phase0), 32'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy || phase !== 4'h8) seen_done = 1'b1;
    end
    chk("ab_quiet_after", 32'(seen_done), 32'h0);

    // Asynchronous reset in the middle of a move.
    @(negedge clk);
    dir = 1'b1; half = 1'b1; steps = SW'(5); period = PW'(4); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mr_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mr_phase", 32'(phase), 32'h0);
    chk("mr_busy_clear", 32'(busy), 32'h0);
    chk("mr_done", 32'(done), 32'h0);
    chk("mr_steps_left", 32'(steps_left), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("mr_idle_busy", 32'(busy), 32'h0);
    chk("mr_idle_phase", 32'(phase), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
